// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the ALU / multiply-divide unit: op codes,
// sequencer state encoding and a small op-class helper.
package alu_mdu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_NOR   = 4'b0100;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT   = 4'b0111;
  localparam logic [OP_W-1:0] OP_MULTU = 4'b1000;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'b1001;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'b1010;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // True for the op codes that run on the iterative engine.
  function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One bit per cycle; hi/lo are loaded only on the final step so they
// hold the previous result for the whole run.
module muldiv_seq
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: shift the next dividend bit into the partial remainder and
  // subtract the divisor if it fits. Upper half = remainder, lower = quotient.
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_acc;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
  assign div_acc   = {div_rem, acc_q[WIDTH-2:0], div_ge};

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Next-state, step and completion logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    fin     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = is_div ? ST_DIV : ST_MUL;
          acc_d   = {{WIDTH{1'b0}}, a};
          opb_d   = b;
          cnt_d   = '0;
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = (state_q == ST_MUL) ? mul_acc : div_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
          hi_d    = acc_d[2*WIDTH-1:WIDTH];
          lo_d    = acc_d[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: accumulator, operand, step counter, hi/lo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered ALU with iterative multiply/divide and HI/LO registers.
// Single-cycle ops complete at the accepting edge; MULTU/DIVU hand off
// to muldiv_seq and complete WIDTH edges later.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             ovf,
  output logic             dbz
);

  logic             accept, mdu_go, single_go, fin;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  logic [WIDTH-1:0] res_q, res_d;
  logic             sel_lo_q, sel_lo_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             is_div_q, is_div_d;
  logic             b_zero_q, b_zero_d;

  assign accept    = start & ~busy;
  assign mdu_go    = accept & is_mdu_op(op);
  assign single_go = accept & ~is_mdu_op(op);

  assign sum  = a + b;
  assign diff = a - b;

  muldiv_seq #(.WIDTH(WIDTH)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (mdu_go),
    .is_div (op == OP_DIVU),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .fin    (fin),
    .hi     (hi),
    .lo     (lo)
  );

  // After a MULTU/DIVU the result is lo itself, so select the lo register
  // rather than copying it; both sources are registers.
  assign result = sel_lo_q ? lo : res_q;
  assign zero   = (result == '0);
  assign ovf    = ovf_q;
  assign dbz    = dbz_q;
  assign done   = done_q;

  // Single-cycle op decode.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // Result/flag update on completion; dbz is recorded at accept and
  // published when the divide finishes.
  always_comb begin
    res_d    = res_q;
    sel_lo_d = sel_lo_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    is_div_d = is_div_q;
    b_zero_d = b_zero_q;
    if (single_go) begin
      res_d    = alu_res;
      ovf_d    = alu_ovf;
      sel_lo_d = 1'b0;
      done_d   = 1'b1;
    end
    if (mdu_go) begin
      is_div_d = (op == OP_DIVU);
      b_zero_d = (b == '0);
    end
    if (fin) begin
      sel_lo_d = 1'b1;
      ovf_d    = 1'b0;
      done_d   = 1'b1;
      if (is_div_q) dbz_d = b_zero_q;
    end
  end

  // Result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      sel_lo_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      is_div_q <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      res_q    <= res_d;
      sel_lo_q <= sel_lo_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      is_div_q <= is_div_d;
      b_zero_q <= b_zero_d;
    end
  end

endmodule
